// File: rtl/stack_arbiter.sv
// Round-robin arbiter sharing one LIFO stack between requesters A and B.
// Tracks occupancy, rejects over/underflow and returns ack/rdata/err per op.
//   state   | meaning
//   IDLE    | wait for request, grant, latch op
//   ISSUE   | push/pop strobe active, count updated
//   CAPTURE | stack read data and error flag sampled
//   ACK     | one-cycle ack to granted requester
module stack_arbiter #(
    parameter int DEPTH = 16,
    parameter int CW    = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a_req,
    input  logic          a_pop,
    input  logic [7:0]    a_data,
    output logic          a_ack,
    output logic [7:0]    a_rdata,
    output logic          a_err,
    input  logic          b_req,
    input  logic          b_pop,
    input  logic [7:0]    b_data,
    output logic          b_ack,
    output logic [7:0]    b_rdata,
    output logic          b_err,
    output logic          stk_push,
    output logic          stk_pop,
    output logic [7:0]    stk_data_in,
    input  logic [7:0]    stk_data_out,
    input  logic          stk_error,
    output logic [CW-1:0] count,
    output logic          err_sticky
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, ACK} state_t;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    state_t state, state_next;
    logic   ptr;        // 0 = A has priority, 1 = B
    logic   gnt;        // 0 = A granted, 1 = B granted
    logic   op_pop;
    logic   rejected;

    logic       grant_valid;
    logic       grant_id;
    logic       sel_pop;
    logic [7:0] sel_data;
    logic       legal;

    always_comb begin
        grant_valid = a_req | b_req;
        grant_id    = (a_req && b_req) ? ptr : b_req;
        sel_pop     = grant_id ? b_pop : a_pop;
        sel_data    = grant_id ? b_data : a_data;
        legal       = sel_pop ? (count != '0) : (count < DEPTH_C);
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_valid) state_next = ISSUE;
            ISSUE:   state_next = CAPTURE;
            CAPTURE: state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr         <= 1'b0;
            gnt         <= 1'b0;
            op_pop      <= 1'b0;
            rejected    <= 1'b0;
            count       <= '0;
            err_sticky  <= 1'b0;
            a_ack       <= 1'b0;
            b_ack       <= 1'b0;
            a_err       <= 1'b0;
            b_err       <= 1'b0;
            a_rdata     <= 8'h00;
            b_rdata     <= 8'h00;
            stk_push    <= 1'b0;
            stk_pop     <= 1'b0;
            stk_data_in <= 8'h00;
        end else begin
            stk_push <= 1'b0;
            stk_pop  <= 1'b0;
            a_ack    <= 1'b0;
            b_ack    <= 1'b0;
            a_err    <= 1'b0;
            b_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        // legality is decided here so the strobe can be registered into ISSUE
                        gnt         <= grant_id;
                        op_pop      <= sel_pop;
                        ptr         <= ~grant_id;
                        rejected    <= ~legal;
                        stk_push    <= legal & ~sel_pop;
                        stk_pop     <= legal & sel_pop;
                        stk_data_in <= sel_data;
                    end
                end
                ISSUE: begin
                    if (!rejected) count <= op_pop ? count - CW'(1) : count + CW'(1);
                end
                CAPTURE: begin
                    if (op_pop) begin
                        if (gnt) b_rdata <= stk_data_out;
                        else     a_rdata <= stk_data_out;
                    end
                    if (stk_error) err_sticky <= 1'b1;
                    a_ack <= ~gnt;
                    b_ack <= gnt;
                    a_err <= ~gnt & (rejected | stk_error);
                    b_err <= gnt & (rejected | stk_error);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter with a behavioural 16-entry LIFO attached.
module tb_stack_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       a_req = 1'b0, a_pop = 1'b0, b_req = 1'b0, b_pop = 1'b0;
    logic [7:0] a_data = 8'h00, b_data = 8'h00;
    logic       a_ack, a_err, b_ack, b_err;
    logic [7:0] a_rdata, b_rdata;
    logic       stk_push, stk_pop, stk_error;
    logic [7:0] stk_data_in;
    logic [7:0] stk_data_out;
    logic [4:0] count;
    logic       err_sticky;
    logic       err_force = 1'b0;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    stack_arbiter #(.DEPTH(16), .CW(5)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_pop(a_pop), .a_data(a_data),
        .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
        .b_req(b_req), .b_pop(b_pop), .b_data(b_data),
        .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_data_in(stk_data_in),
        .stk_data_out(stk_data_out), .stk_error(stk_error),
        .count(count), .err_sticky(err_sticky)
    );

    // behavioural stack: read data valid the cycle after a pop
    logic [7:0] mem [16];
    int         sp;
    assign stk_error = err_force;

    always @(posedge clk) begin
        if (reset) begin
            sp           <= 0;
            stk_data_out <= 8'h00;
        end else if (stk_push && sp < 16) begin
            mem[sp] <= stk_data_in;
            sp      <= sp + 1;
        end else if (stk_pop && sp > 0) begin
            stk_data_out <= mem[sp-1];
            sp           <= sp - 1;
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        a_req = 1'b0;
        b_req = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // one full operation from an IDLE cycle (cycle 0) to the following IDLE cycle (cycle 4)
    task automatic op(input bit is_b, input bit pop, input logic [7:0] d, input bit exp_err,
                      input bit legal, input bit inj, input logic [7:0] exp_rd, input string tag);
        if (is_b) begin b_req = 1'b1; b_pop = pop; b_data = d; end
        else      begin a_req = 1'b1; a_pop = pop; a_data = d; end
        tick();
        chk({tag, "_push"}, {7'd0, stk_push}, {7'd0, legal && !pop});
        chk({tag, "_pop"},  {7'd0, stk_pop},  {7'd0, legal && pop});
        if (legal && !pop) chk({tag, "_wdata"}, stk_data_in, d);
        tick();
        err_force = inj;
        chk({tag, "_early_ack"}, {7'd0, is_b ? b_ack : a_ack}, 8'd0);
        tick();
        err_force = 1'b0;
        chk({tag, "_ack"},   {7'd0, is_b ? b_ack : a_ack}, 8'd1);
        chk({tag, "_oack"},  {7'd0, is_b ? a_ack : b_ack}, 8'd0);
        chk({tag, "_err"},   {7'd0, is_b ? b_err : a_err}, {7'd0, exp_err});
        if (pop && legal) chk({tag, "_rdata"}, is_b ? b_rdata : a_rdata, exp_rd);
        a_req = 1'b0;
        b_req = 1'b0;
        tick();
        chk({tag, "_ack_drop"}, {7'd0, is_b ? b_ack : a_ack}, 8'd0);
    endtask

    initial begin
        do_reset();
        chk("rst_count",   {3'd0, count}, 8'd0);
        chk("rst_sticky",  {7'd0, err_sticky}, 8'd0);
        chk("rst_acks",    {6'd0, a_ack, b_ack}, 8'd0);
        chk("rst_errs",    {6'd0, a_err, b_err}, 8'd0);
        chk("rst_strobes", {6'd0, stk_push, stk_pop}, 8'd0);
        chk("rst_a_rdata", a_rdata, 8'h00);
        chk("rst_b_rdata", b_rdata, 8'h00);
        chk("rst_wdata",   stk_data_in, 8'h00);

        // single push then pop
        op(1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h00, "pushA5");
        chk("pushA5_count", {3'd0, count}, 8'd1);
        op(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, "popA5");
        chk("popA5_count", {3'd0, count}, 8'd0);

        // simultaneous requests after reset: A wins first
        do_reset();
        a_req = 1'b1; a_pop = 1'b0; a_data = 8'h11;
        b_req = 1'b1; b_pop = 1'b0; b_data = 8'h22;
        tick();
        chk("sim_c1_push",  {7'd0, stk_push}, 8'd1);
        chk("sim_c1_wdata", stk_data_in, 8'h11);
        tick();
        tick();
        chk("sim_c3_a_ack", {7'd0, a_ack}, 8'd1);
        chk("sim_c3_b_ack", {7'd0, b_ack}, 8'd0);
        a_req = 1'b0;
        tick();
        tick();
        chk("sim_c5_push",  {7'd0, stk_push}, 8'd1);
        chk("sim_c5_wdata", stk_data_in, 8'h22);
        tick();
        tick();
        chk("sim_c7_b_ack", {7'd0, b_ack}, 8'd1);
        chk("sim_c7_a_ack", {7'd0, a_ack}, 8'd0);
        b_req = 1'b0;
        tick();
        chk("sim_count", {3'd0, count}, 8'd2);
        op(1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 8'h22, "pop22");
        op(1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 8'h11, "pop11");

        // underflow
        op(1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, "underflow");
        chk("uf_count",  {3'd0, count}, 8'd0);
        chk("uf_sticky", {7'd0, err_sticky}, 8'd0);

        // overflow
        for (int i = 0; i < 16; i++)
            op(1'b0, 1'b0, 8'(i), 1'b0, 1'b1, 1'b0, 8'h00, "fill");
        chk("full_count", {3'd0, count}, 8'd16);
        op(1'b0, 1'b0, 8'hEE, 1'b1, 1'b0, 1'b0, 8'h00, "overflow");
        chk("of_count", {3'd0, count}, 8'd16);
        for (int i = 15; i >= 0; i--)
            op(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 8'(i), "drain");
        chk("drain_count", {3'd0, count}, 8'd0);

        // stack error injected during CAPTURE of a legal push
        op(1'b0, 1'b0, 8'h77, 1'b1, 1'b1, 1'b1, 8'h00, "inject");
        chk("inj_sticky", {7'd0, err_sticky}, 8'd1);
        chk("inj_count",  {3'd0, count}, 8'd1);
        op(1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 8'h77, "post_inj");
        chk("inj_sticky_hold", {7'd0, err_sticky}, 8'd1);
        do_reset();
        chk("inj_sticky_clr", {7'd0, err_sticky}, 8'd0);

        // reset during ISSUE of an A push
        a_req = 1'b1; a_pop = 1'b0; a_data = 8'h99;
        tick();
        chk("mid_issue_push", {7'd0, stk_push}, 8'd1);
        reset = 1'b1;
        a_req = 1'b0;
        tick();
        reset = 1'b0;
        chk("mid_count", {3'd0, count}, 8'd0);
        for (int i = 0; i < 4; i++) begin
            chk("mid_no_ack", {7'd0, a_ack}, 8'd0);
            tick();
        end
        chk("mid_count_after", {3'd0, count}, 8'd0);
        a_req = 1'b1; a_pop = 1'b0; a_data = 8'h31;
        b_req = 1'b1; b_pop = 1'b0; b_data = 8'h32;
        tick();
        chk("mid_sim_wdata", stk_data_in, 8'h31);
        tick();
        tick();
        chk("mid_sim_a_ack", {7'd0, a_ack}, 8'd1);
        chk("mid_sim_b_ack", {7'd0, b_ack}, 8'd0);
        a_req = 1'b0;
        repeat (4) tick();
        chk("mid_sim_b_ack2", {7'd0, b_ack}, 8'd1);
        b_req = 1'b0;
        tick();
        chk("mid_sim_count", {3'd0, count}, 8'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/stack_arbiter.md
# stack_arbiter

Shares a single DEPTH-entry, 8-bit LIFO stack between two independent requesters (A and B) using round-robin arbitration. It drives the stack's push/pop strobes and write data, and captures the pop read data. It tracks occupancy and rejects overflow/underflow requests before they reach the stack. It returns a one-cycle acknowledge, read data and error flag to the granted requester.

## Interface
- DEPTH, 16, stack entries; must equal the depth of the attached stack instance
- CW, 5, occupancy counter width; must satisfy 2^CW > DEPTH
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- a_req  in  1  requester A request; held with a_pop/a_data stable until a_ack
- a_pop  in  1  A operation: 0 = push, 1 = pop
- a_data  in  8  A push data
- a_ack  out  1  A completion pulse, exactly one cycle
- a_rdata  out  8  A pop data; valid while a_ack=1 and a_pop=1
- a_err  out  1  A operation rejected/failed; valid while a_ack=1
- b_req, b_pop, b_data, b_ack, b_rdata, b_err: identical to A, for requester B
- stk_push  out  1  push strobe to stack, one cycle
- stk_pop  out  1  pop strobe to stack, one cycle
- stk_data_in  out  8  push data to stack
- stk_data_out  in  8  stack read data; valid the cycle after stk_pop
- stk_error  in  1  stack over/underflow flag; sampled in CAPTURE
- count  out  CW  current occupancy, 0..DEPTH
- err_sticky  out  1  set on any stk_error observed; cleared only by reset

## Operation
- FSM: IDLE -> ISSUE -> CAPTURE -> ACK -> IDLE. Every transition is unconditional except the one leaving IDLE.
- IDLE:
  - If neither request is high, stay in IDLE.
  - If one request is high, grant it.
  - If both are high, grant the requester named by the priority pointer.
  - On grant, latch the requester id, op and data, then go to ISSUE.
  - After every grant, including rejected ones, the pointer moves to the other requester.
- ISSUE:
  - Legal when: push with count < DEPTH, or pop with count > 0.
  - Legal op: pulse stk_push or stk_pop for this cycle, with stk_data_in = latched data. count is updated (+1 push, -1 pop) at the end of this cycle.
  - Illegal op: no strobe, count unchanged, and the rejected flag is set.
- CAPTURE:
  - For a pop, register stk_data_out into the granted rdata.
  - If stk_error=1, set the op error and err_sticky.
  - count is never corrected from stk_error.
- ACK:
  - The granted requester's ack is 1, and its err = rejected OR stk_error-captured.
  - Requests are not sampled in ACK.
  - A requester must drop req, or present a new request, by the cycle after ack.
- Non-granted requester outputs: ack=0, err=0, rdata holds its last value.
- stk_push and stk_pop are never high simultaneously, and never high outside ISSUE.

## Timing
- Reset values:
  - state IDLE, pointer = A, count = 0, err_sticky = 0
  - a_ack, b_ack, a_err, b_err, stk_push, stk_pop = 0
  - a_rdata, b_rdata, stk_data_in = 8'h00
- All outputs are registered.
- Latency: req high in IDLE in cycle N -> strobe in cycle N+1 -> ack in cycle N+3.
- Throughput: one operation per 4 cycles. The earliest re-grant is in the IDLE cycle N+4.
- Reset asserted mid-operation: the FSM returns to IDLE on the next edge. No ack is issued for the aborted op, count = 0, and the stack is reset on the same edge.
- Boundaries:
  - count == DEPTH: a push is rejected.
  - count == 0: a pop is rejected.
  - count never wraps.

## Test plan
- **Single push then pop:** reset; A pushes 8'hA5 (req cycle 0).
  - Required: stk_push=1 in cycle 1; a_ack=1, a_err=0 in cycle 3; count=1.
  - Then A pops. Required: a_rdata=8'hA5, a_err=0, count=0.
- **Simultaneous requests:** A push 8'h11 and B push 8'h22 asserted together after reset.
  - Required: A acked first (cycle 3), B acked next (cycle 7), count=2.
  - Two pops by B then return 8'h22, then 8'h11 (LIFO).
- **Underflow:** pop from B at count=0.
  - Required: no stk_pop pulse, b_ack=1 with b_err=1 in cycle 3, count stays 0, err_sticky=0.
- **Overflow:** push DEPTH=16 values 8'h00..8'h0F via A.
  - Required: count=16.
  - A 17th push must return a_err=1 with no stk_push pulse.
  - The following 16 pops must return 8'h0F down to 8'h00.
- **Stack error injection:** force stk_error=1 during CAPTURE of a legal push.
  - Required: ack with err=1, and err_sticky=1 until reset.
- **Reset mid-op:** assert reset in the ISSUE cycle of an A push.
  - Required: a_ack never asserted, count=0, and the pointer is back to A (a subsequent simultaneous request grants A first).
